// File: rtl/cp_insert_stream.sv
// Cyclic-prefix insertion: captures IFFT symbols into a ping-pong buffer and
// replays each as its last cp_len samples followed by the full symbol.
module cp_insert_stream #(
   parameter int WIDTH        = 26,
   parameter int N_FFT        = 2048,
   parameter int CP_LONG      = 160,
   parameter int CP_SHORT     = 144,
   parameter int SYM_PER_SLOT = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_r,
   input  logic [WIDTH-1:0] in_i,
   output logic             in_ready,
   input  logic             slot_sync,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_r,
   output logic [WIDTH-1:0] out_i,
   output logic             out_sos,
   output logic             out_eos,
   output logic [3:0]       sym_idx,
   output logic             overflow
);
   // state | meaning
   // IDLE  | waiting for a full bank to read
   // CP    | replaying the tail of the symbol as cyclic prefix
   // BODY  | replaying samples 0..N_FFT-1

   localparam int AW = $clog2(N_FFT);
   localparam logic [AW-1:0] ADDR_LAST   = AW'(N_FFT - 1);
   localparam logic [AW-1:0] START_LONG  = AW'(N_FFT - CP_LONG);
   localparam logic [AW-1:0] START_SHORT = AW'(N_FFT - CP_SHORT);
   localparam logic [3:0]    SYM_LAST    = 4'(SYM_PER_SLOT - 1);
   localparam logic [3:0]    SYM_MID     = 4'(SYM_PER_SLOT / 2);

   typedef enum logic [1:0] {IDLE, CP, BODY} state_t;
   state_t state, state_nxt;

   logic [2*WIDTH-1:0] mem [0:2*N_FFT-1];
   logic [2*WIDTH-1:0] rd_data;
   logic [1:0]         full, full_nxt;
   logic               wr_bank, rd_bank, rd_bank_nxt;
   logic [AW-1:0]      wr_cnt, rd_addr, rd_addr_nxt, cp_start, cp_start_nxt;
   logic [3:0]         sym_cur, sym_cur_nxt, sym_new;
   logic               sync_pend, sync_pend_nxt, sync;
   logic               accept, wr_done, rd_en, rd_last;

   function automatic logic [AW-1:0] start_of(input logic [3:0] s);
      return (s == 4'd0 || s == SYM_MID) ? START_LONG : START_SHORT;
   endfunction

   assign accept  = in_valid & in_ready;
   assign wr_done = accept & (wr_cnt == ADDR_LAST);
   assign rd_last = (state == BODY) & (rd_addr == ADDR_LAST);
   assign sync    = sync_pend | slot_sync;

   always_comb begin
      full_nxt = full;
      if (rd_last) full_nxt[rd_bank] = 1'b0;
      if (wr_done) full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (accept) mem[{wr_bank, wr_cnt}] <= {in_r, in_i};
      rd_data <= mem[{rd_bank, rd_addr}];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full     <= '0;
         wr_bank  <= 1'b0;
         wr_cnt   <= '0;
         in_ready <= 1'b1;
         overflow <= 1'b0;
      end else begin
         full     <= full_nxt;
         wr_bank  <= wr_bank ^ wr_done;
         in_ready <= ~full_nxt[wr_bank ^ wr_done];
         if (accept) wr_cnt <= wr_cnt + 1'b1;
         if (in_valid & ~in_ready) overflow <= 1'b1;
      end
   end

   always_comb begin
      state_nxt     = state;
      rd_addr_nxt   = rd_addr;
      rd_bank_nxt   = rd_bank;
      sym_cur_nxt   = sym_cur;
      sync_pend_nxt = sync;
      cp_start_nxt  = cp_start;
      sym_new       = sym_cur;
      rd_en         = 1'b0;
      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               sym_new       = sync ? 4'd0 : sym_cur;
               sym_cur_nxt   = sym_new;
               sync_pend_nxt = 1'b0;
               cp_start_nxt  = start_of(sym_new);
               rd_addr_nxt   = start_of(sym_new);
               state_nxt     = CP;
            end
         end
         CP: begin
            rd_en       = 1'b1;
            rd_addr_nxt = rd_addr + 1'b1;
            if (rd_addr == ADDR_LAST) state_nxt = BODY;
         end
         BODY: begin
            rd_en       = 1'b1;
            rd_addr_nxt = rd_addr + 1'b1;
            if (rd_last) begin
               // a slot_sync seen during this symbol only affects the next one
               sym_new       = sync ? 4'd0 : ((sym_cur == SYM_LAST) ? 4'd0 : sym_cur + 4'd1);
               sym_cur_nxt   = sym_new;
               sync_pend_nxt = 1'b0;
               rd_bank_nxt   = ~rd_bank;
               if (full[~rd_bank]) begin
                  cp_start_nxt = start_of(sym_new);
                  rd_addr_nxt  = start_of(sym_new);
                  state_nxt    = CP;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rd_addr   <= '0;
         rd_bank   <= 1'b0;
         sym_cur   <= '0;
         sync_pend <= 1'b0;
         cp_start  <= '0;
         out_valid <= 1'b0;
         out_sos   <= 1'b0;
         out_eos   <= 1'b0;
         sym_idx   <= '0;
      end else begin
         state     <= state_nxt;
         rd_addr   <= rd_addr_nxt;
         rd_bank   <= rd_bank_nxt;
         sym_cur   <= sym_cur_nxt;
         sync_pend <= sync_pend_nxt;
         cp_start  <= cp_start_nxt;
         out_valid <= rd_en;
         out_sos   <= (state == CP) & (rd_addr == cp_start);
         out_eos   <= rd_last;
         if (rd_en) sym_idx <= sym_cur;
      end
   end

   // read data is not reset, so gate it with the reset-cleared strobe
   assign out_r = out_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
   assign out_i = out_valid ? rd_data[WIDTH-1:0]       : '0;

endmodule
